equiv_stream_monitor: RTL and testbench

//  Parametrised sequential equivalence monitor for the equivalence-checking miters.
//  It compares output streams y_a/y_b from two design instances (top_1/top_2 style)
//  and compensates a fixed pipeline skew between them. After a warm-up window it

---
 rtl/equiv_stream_monitor.sv | 162 ++++++++++++++++
 tb/tb_equiv_stream_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/equiv_stream_monitor.sv
// Purpose : skew-compensating equivalence monitor for miter outputs y_a/y_b;
//           ignores a warm-up window, then checks every enabled cycle.
// Latency : a compare happens at a clock edge; mismatch and counters update on that edge.
// Backpr. : none; en=0 freezes delay lines, counters and FSM.
// Ports   : clk, rst_n (async, active-low), en (sample valid), clr (sync clear),
//           y_a/y_b (streams under compare), armed, mismatch (pulse), fail (sticky),
//           mismatch_cnt/cycle_cnt (saturating), first_cycle/first_diff (first failure).
module equiv_stream_monitor #(
  parameter int WIDTH  = 91,
  parameter int LAT_A  = 0,
  parameter int LAT_B  = 0,
  parameter int WARMUP = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] y_a,
  input  logic [WIDTH-1:0] y_b,
  output logic             armed,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] first_cycle,
  output logic [WIDTH-1:0] first_diff
);

  // Warm-up must cover the longer delay line so both aligned samples are real data.
  // WARMUP + max(LAT_A, LAT_B) is expected to be at least 1.
  localparam int TOTAL = WARMUP + ((LAT_A > LAT_B) ? LAT_A : LAT_B);
  localparam int WC_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {
    S_WARM  = 2'd0,
    S_CHECK = 2'd1,
    S_FAIL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WC_W-1:0]  warm_cnt;
  logic             warm_done;
  logic [WIDTH-1:0] a_al, b_al;
  logic             neq;

  // ---------------- alignment delay lines ----------------
  generate
    if (LAT_A == 0) begin : g_a_wire
      assign a_al = y_a;
    end else begin : g_a_dly
      logic [WIDTH-1:0] sr [LAT_A];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT_A; i++) sr[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < LAT_A; i++) sr[i] <= '0;
        end else if (en) begin
          sr[0] <= y_a;
          for (int i = 1; i < LAT_A; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_al = sr[LAT_A-1];
    end

    if (LAT_B == 0) begin : g_b_wire
      assign b_al = y_b;
    end else begin : g_b_dly
      logic [WIDTH-1:0] sr [LAT_B];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT_B; i++) sr[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < LAT_B; i++) sr[i] <= '0;
        end else if (en) begin
          sr[0] <= y_b;
          for (int i = 1; i < LAT_B; i++) sr[i] <= sr[i-1];
        end
      end
      assign b_al = sr[LAT_B-1];
    end
  endgenerate

  // X/Z on either side must be flagged in simulation; synthesis only sees 0/1.
`ifdef SYNTHESIS
  assign neq = (a_al != b_al);
`else
  assign neq = (a_al !== b_al);
`endif

  assign warm_done = (warm_cnt == WC_W'(TOTAL - 1));
  assign armed     = (state != S_WARM);
  assign fail      = (state == S_FAIL);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WARM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_WARM;
    end else if (en) begin
      case (state)
        S_WARM:  if (warm_done) state_nxt = S_CHECK;
        S_CHECK: if (neq)       state_nxt = S_FAIL;
        default: state_nxt = state;
      endcase
    end
  end

  // ---------------- warm-up counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= '0;
    end else if (clr) begin
      warm_cnt <= '0;
    end else if (en && state == S_WARM) begin
      warm_cnt <= warm_done ? '0 : warm_cnt + WC_W'(1);
    end
  end

  // ---------------- compare datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
      cycle_cnt    <= '0;
      first_cycle  <= '0;
      first_diff   <= '0;
    end else if (clr) begin
      // clr wins over a same-cycle mismatch: the compare result is dropped.
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
      cycle_cnt    <= '0;
      first_cycle  <= '0;
      first_diff   <= '0;
    end else begin
      mismatch <= 1'b0;
      if (en && armed) begin
        if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (neq) begin
          mismatch <= 1'b1;
          if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
          // Only the transition CHECK->FAIL captures; later mismatches leave it alone.
          if (state == S_CHECK) begin
            first_cycle <= cycle_cnt;
            first_diff  <= a_al ^ b_al;
          end
        end
      end
    end
  end

`ifdef FORMAL
  // Miters bind their equivalence obligation to this property.
  no_fail: assert property (@(posedge clk) disable iff (!rst_n) !fail);
`endif

endmodule

// File: tb/tb_equiv_stream_monitor.sv
// Bench for equiv_stream_monitor: three instances (defaults, LAT_A=3, CNT_W=4)
// share clock, reset, en, clr and y_a; each has its own y_b.
module tb_equiv_stream_monitor;

  logic clk = 1'b0;
  logic rst_n, en, clr;
  logic [90:0] y_a, yb0, yb3, yb5;

  logic        arm0, mm0, fail0;
  logic [15:0] mcnt0, ccnt0, fc0;
  logic [90:0] fd0;
  logic        arm3, mm3, fail3;
  logic [15:0] mcnt3, ccnt3, fc3;
  logic [90:0] fd3;
  logic        arm5, mm5, fail5;
  logic [3:0]  mcnt5, ccnt5, fc5;
  logic [90:0] fd5;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  equiv_stream_monitor u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .y_a(y_a), .y_b(yb0),
    .armed(arm0), .mismatch(mm0), .fail(fail0), .mismatch_cnt(mcnt0),
    .cycle_cnt(ccnt0), .first_cycle(fc0), .first_diff(fd0));

  equiv_stream_monitor #(.LAT_A(3)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .y_a(y_a), .y_b(yb3),
    .armed(arm3), .mismatch(mm3), .fail(fail3), .mismatch_cnt(mcnt3),
    .cycle_cnt(ccnt3), .first_cycle(fc3), .first_diff(fd3));

  equiv_stream_monitor #(.CNT_W(4)) u5 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .y_a(y_a), .y_b(yb5),
    .armed(arm5), .mismatch(mm5), .fail(fail5), .mismatch_cnt(mcnt5),
    .cycle_cnt(ccnt5), .first_cycle(fc5), .first_diff(fd5));

  function automatic logic [90:0] rnd91();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[90:0];
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    y_a = '0; yb0 = '0; yb3 = '0; yb5 = '0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (arm0 !== 1'b0) begin bad++; $display("FAIL reset_armed got=%0b exp=0", arm0); end
    total++; if (fail0 !== 1'b0) begin bad++; $display("FAIL reset_fail got=%0b exp=0", fail0); end
    total++; if (mm0 !== 1'b0) begin bad++; $display("FAIL reset_mismatch got=%0b exp=0", mm0); end
    total++; if ({mcnt0, ccnt0, fc0} !== 48'd0) begin bad++;
      $display("FAIL reset_counters got=%0h/%0h/%0h exp=0/0/0", mcnt0, ccnt0, fc0); end
    total++; if (fd0 !== 91'd0) begin bad++; $display("FAIL reset_first_diff got=%0h exp=0", fd0); end
  endtask

  task automatic test_equal_stream();
    int pulses = 0;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      y_a = rnd91(); yb0 = y_a;
      cyc();
      if (mm0 === 1'b1) pulses++;
    end
    en = 1'b0;
    total++; if (fail0 !== 1'b0) begin bad++; $display("FAIL eq_fail got=%0b exp=0", fail0); end
    total++; if (mcnt0 !== 16'd0) begin bad++; $display("FAIL eq_mismatch_cnt got=%0d exp=0", mcnt0); end
    total++; if (ccnt0 !== 16'd96) begin bad++; $display("FAIL eq_cycle_cnt got=%0d exp=96", ccnt0); end
    total++; if (pulses != 0) begin bad++; $display("FAIL eq_pulses got=%0d exp=0", pulses); end
    total++; if (arm0 !== 1'b1) begin bad++; $display("FAIL eq_armed got=%0b exp=1", arm0); end
  endtask

  task automatic test_single_flip();
    logic [90:0] exp_diff;
    int pulses = 0;
    exp_diff = '0; exp_diff[90] = 1'b1;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      y_a = rnd91();
      yb0 = (k == 10) ? (y_a ^ exp_diff) : y_a;
      cyc();
      if (mm0 === 1'b1) pulses++;
      if (k == 10) begin
        total++; if (mm0 !== 1'b1) begin bad++; $display("FAIL flip_pulse got=%0b exp=1", mm0); end
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL flip_pulses got=%0d exp=1", pulses); end
    total++; if (fail0 !== 1'b1) begin bad++; $display("FAIL flip_fail got=%0b exp=1", fail0); end
    total++; if (fc0 !== 16'd6) begin bad++; $display("FAIL flip_first_cycle got=%0d exp=6", fc0); end
    total++; if (fd0 !== exp_diff) begin bad++; $display("FAIL flip_first_diff got=%0h exp=%0h", fd0, exp_diff); end
    total++; if (mcnt0 !== 16'd1) begin bad++; $display("FAIL flip_mismatch_cnt got=%0d exp=1", mcnt0); end
    total++; if (ccnt0 !== 16'd16) begin bad++; $display("FAIL flip_cycle_cnt got=%0d exp=16", ccnt0); end
    // en=0 with differing inputs: nothing is compared or counted
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      y_a = rnd91(); yb0 = ~y_a;
      cyc();
      total++; if (mm0 !== 1'b0) begin bad++; $display("FAIL idle_pulse got=%0b exp=0", mm0); end
    end
    total++; if (ccnt0 !== 16'd16 || mcnt0 !== 16'd1) begin bad++;
      $display("FAIL idle_counts got=%0d/%0d exp=16/1", ccnt0, mcnt0); end
    total++; if (fc0 !== 16'd6 || fd0 !== exp_diff) begin bad++;
      $display("FAIL idle_captures got=%0d/%0h exp=6/%0h", fc0, fd0, exp_diff); end
  endtask

  task automatic test_latency();
    logic [90:0] hist [$];
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      y_a = rnd91();
      hist.push_back(y_a);
      yb3 = (k >= 3) ? hist[k-3] : '0;
      cyc();
      if (k == 6) begin
        total++; if (arm3 !== 1'b1) begin bad++; $display("FAIL lat_armed_at7 got=%0b exp=1", arm3); end
      end
      if (k == 5) begin
        total++; if (arm3 !== 1'b0) begin bad++; $display("FAIL lat_armed_at6 got=%0b exp=0", arm3); end
      end
    end
    total++; if (fail3 !== 1'b0 || mcnt3 !== 16'd0) begin bad++;
      $display("FAIL lat_aligned got=%0b/%0d exp=0/0", fail3, mcnt3); end
    total++; if (ccnt3 !== 16'd13) begin bad++; $display("FAIL lat_cycle_cnt got=%0d exp=13", ccnt3); end
    // undelayed y_b: the first armed compare must fail
    do_reset();
    hist.delete();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      y_a = rnd91();
      hist.push_back(y_a);
      yb3 = y_a;
      cyc();
      if (k == 6) begin
        total++; if (fail3 !== 1'b0) begin bad++; $display("FAIL lat_skew_early got=%0b exp=0", fail3); end
      end
    end
    total++; if (fail3 !== 1'b1 || mm3 !== 1'b1) begin bad++;
      $display("FAIL lat_skew_fail got=%0b/%0b exp=1/1", fail3, mm3); end
    total++; if (fc3 !== 16'd0) begin bad++; $display("FAIL lat_skew_first_cycle got=%0d exp=0", fc3); end
    total++; if (fd3 !== (hist[4] ^ hist[7])) begin bad++;
      $display("FAIL lat_skew_first_diff got=%0h exp=%0h", fd3, hist[4] ^ hist[7]); end
  endtask

  task automatic test_clr_mismatch();
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      y_a = rnd91(); yb0 = y_a;
      cyc();
    end
    total++; if (ccnt0 !== 16'd2) begin bad++; $display("FAIL clr_pre_cycle_cnt got=%0d exp=2", ccnt0); end
    y_a = rnd91(); yb0 = ~y_a; clr = 1'b1;
    cyc();
    clr = 1'b0;
    total++; if (fail0 !== 1'b0 || mm0 !== 1'b0) begin bad++;
      $display("FAIL clr_fail got=%0b/%0b exp=0/0", fail0, mm0); end
    total++; if ({mcnt0, ccnt0, fc0} !== 48'd0 || fd0 !== 91'd0) begin bad++;
      $display("FAIL clr_counters got=%0d/%0d/%0d/%0h exp=0", mcnt0, ccnt0, fc0, fd0); end
    total++; if (arm0 !== 1'b0) begin bad++; $display("FAIL clr_armed got=%0b exp=0", arm0); end
    // warm-up restarts from zero after clr
    for (int k = 0; k < 4; k++) begin
      y_a = rnd91(); yb0 = ~y_a;
      cyc();
      total++; if (arm0 !== (k == 3)) begin bad++;
        $display("FAIL clr_rewarm k=%0d got=%0b exp=%0b", k, arm0, (k == 3)); end
    end
    total++; if (fail0 !== 1'b0) begin bad++; $display("FAIL clr_rewarm_fail got=%0b exp=0", fail0); end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      y_a = rnd91(); yb5 = ~y_a;
      cyc();
    end
    en = 1'b0;
    total++; if (mcnt5 !== 4'd15) begin bad++; $display("FAIL sat_mismatch_cnt got=%0d exp=15", mcnt5); end
    total++; if (ccnt5 !== 4'd15) begin bad++; $display("FAIL sat_cycle_cnt got=%0d exp=15", ccnt5); end
    total++; if (fc5 !== 4'd0) begin bad++; $display("FAIL sat_first_cycle got=%0d exp=0", fc5); end
    total++; if (fail5 !== 1'b1) begin bad++; $display("FAIL sat_fail got=%0b exp=1", fail5); end
    total++; if (fd5 !== {91{1'b1}}) begin bad++; $display("FAIL sat_first_diff got=%0h exp=all-ones", fd5); end
  endtask

  task automatic test_async_reset();
    logic en_pat [6];
    int n_en;
    en_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      y_a = rnd91(); yb0 = (k == 4) ? ~y_a : y_a;
      cyc();
    end
    total++; if (fail0 !== 1'b1) begin bad++; $display("FAIL ar_pre_fail got=%0b exp=1", fail0); end
    rst_n = 1'b0;
    #2;
    total++; if ({arm0, fail0, mm0} !== 3'b000 || {mcnt0, ccnt0, fc0} !== 48'd0 || fd0 !== 91'd0) begin bad++;
      $display("FAIL ar_async got=%0b%0b%0b/%0d/%0d/%0d/%0h exp=0", arm0, fail0, mm0, mcnt0, ccnt0, fc0, fd0); end
    for (int k = 0; k < 3; k++) begin
      en = k[0];
      cyc();
    end
    total++; if (arm0 !== 1'b0 || fail0 !== 1'b0) begin bad++;
      $display("FAIL ar_held got=%0b/%0b exp=0/0", arm0, fail0); end
    rst_n = 1'b1;
    n_en = 0;
    for (int k = 0; k < 6; k++) begin
      en = en_pat[k];
      y_a = rnd91(); yb0 = y_a;
      cyc();
      if (en_pat[k]) n_en++;
      total++; if (arm0 !== (n_en >= 4)) begin bad++;
        $display("FAIL ar_rewarm k=%0d got=%0b exp=%0b", k, arm0, (n_en >= 4)); end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal_stream();
    test_single_flip();
    test_latency();
    test_clr_mismatch();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
